dist_forwarding_pipeline: RTL and testbench

Parametrised forwarding unit for the distribution register file. Tracks in-flight distribution-register writes across `DEPTH` pipeline stages after ID in its own shift register. For each of `NUM_SRC` ID-stage source addresses it selects the youngest matching producer. When the matching result is not yet available, it raises a hazard stall and inserts a bubble. It sits beside the ID stage and drives the distribution operand mux selects.

---
 rtl/dist_fwd_pkg.sv | 18 +
 rtl/dist_fwd_match.sv | 32 +++
 rtl/dist_forwarding_pipeline.sv | 77 +++++++
 tb/tb_dist_forwarding_pipeline.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dist_fwd_pkg.sv
// Shared types for the distribution-register forwarding unit.
// Late-result stalling is enabled by DIST_FWD_LATE_STALL_EN.
package dist_fwd_pkg;

  localparam int DIST_ADDR_W = 5;
  localparam int ADDR_MAX    = 16;
  localparam int SEL_NONE    = 0;

  typedef struct packed {
    logic                valid;
    logic                dreg_write;
    logic [ADDR_MAX-1:0] dest_addr;
`ifdef DIST_FWD_LATE_STALL_EN
    logic                late;
`endif
  } dist_fwd_entry_t;

endpackage

// File: rtl/dist_fwd_match.sv
// Priority comparator for one source operand over all tracked stages.
// Late-hit output is live only with DIST_FWD_LATE_STALL_EN.
module dist_fwd_match
  import dist_fwd_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = DIST_ADDR_W,
  parameter int SEL_W  = $clog2(DEPTH+1)
) (
  input  dist_fwd_entry_t [DEPTH-1:0] entries,
  input  logic [ADDR_W-1:0]           src_addr,
  output logic [SEL_W-1:0]            sel,
  output logic                        late_hit
);

  always_comb begin
    sel      = SEL_W'(SEL_NONE);
    late_hit = 1'b0;
    // walk oldest to youngest so the youngest match overrides
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (entries[k].valid &&
          entries[k].dreg_write &&
          entries[k].dest_addr == ADDR_MAX'(src_addr) &&
          src_addr != '0)
        sel = SEL_W'(k+1);
    end
`ifdef DIST_FWD_LATE_STALL_EN
    late_hit = (sel == SEL_W'(1)) && entries[0].late;
`endif
  end

endmodule

// File: rtl/dist_forwarding_pipeline.sv
// Distribution-register forwarding unit: stage tracker plus per-source select.
// Define DIST_FWD_LATE_STALL_EN to stall ID on late producers in stage 0.
module dist_forwarding_pipeline
  import dist_fwd_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int ADDR_W  = DIST_ADDR_W,
  parameter int SEL_W   = $clog2(DEPTH+1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     id_valid,
  input  logic                     id_dreg_write,
  input  logic [ADDR_W-1:0]        id_dest_addr,
  input  logic                     id_late,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
  input  logic                     pipe_stall,
  input  logic                     pipe_flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic [NUM_SRC-1:0]       fwd_hit,
  output logic                     hazard_stall
);

  dist_fwd_entry_t [DEPTH-1:0] stages;
  dist_fwd_entry_t             entry_in;
  logic [NUM_SRC-1:0]          late_hit;
  logic                        bubble;

  always_comb begin
    entry_in            = '0;
    entry_in.valid      = id_valid;
    entry_in.dreg_write = id_dreg_write;
    entry_in.dest_addr  = ADDR_MAX'(id_dest_addr);
`ifdef DIST_FWD_LATE_STALL_EN
    entry_in.late       = id_late;
`endif
  end

`ifndef DIST_FWD_LATE_STALL_EN
  logic unused_late;
  assign unused_late = id_late;
`endif

  for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
    dist_fwd_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .SEL_W  (SEL_W)
    ) u_match (
      .entries  (stages),
      .src_addr (id_src_addr[n*ADDR_W +: ADDR_W]),
      .sel      (fwd_sel[n*SEL_W +: SEL_W]),
      .late_hit (late_hit[n])
    );
    assign fwd_hit[n] = |fwd_sel[n*SEL_W +: SEL_W];
  end

  // late_hit is constant 0 when late tracking is compiled out
  assign hazard_stall = id_valid & (|late_hit);
  assign bubble       = pipe_flush | hazard_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stages <= '0;
    end else if (!pipe_stall) begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        stages[k] <= stages[k-1];
`ifdef DIST_FWD_LATE_STALL_EN
        stages[k].late <= 1'b0;
`endif
      end
      stages[0] <= bubble ? '0 : entry_in;
    end
  end

endmodule

// File: tb/tb_dist_forwarding_pipeline.sv
// Directed self-checking bench for dist_forwarding_pipeline.
module tb_dist_forwarding_pipeline;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic       id_dreg_write;
  logic [4:0] id_dest_addr;
  logic       id_late;
  logic [9:0] id_src_addr;
  logic       pipe_stall;
  logic       pipe_flush;
  logic [3:0] fwd_sel;
  logic [1:0] fwd_hit;
  logic       hazard_stall;

  int total = 0;
  int bad   = 0;
  logic [6:0] want;

  dist_forwarding_pipeline dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_dreg_write(id_dreg_write),
    .id_dest_addr (id_dest_addr),
    .id_late      (id_late),
    .id_src_addr  (id_src_addr),
    .pipe_stall   (pipe_stall),
    .pipe_flush   (pipe_flush),
    .fwd_sel      (fwd_sel),
    .fwd_hit      (fwd_hit),
    .hazard_stall (hazard_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ev(
    input logic st, input logic [1:0] s1, input logic [1:0] s0);
    return {st, s1 != 2'd0, s0 != 2'd0, s1, s0};
  endfunction

  task automatic drive(input logic v, input logic w,
                       input logic [4:0] d, input logic l,
                       input logic [4:0] s1, input logic [4:0] s0);
    id_valid      = v;
    id_dreg_write = w;
    id_dest_addr  = d;
    id_late       = l;
    id_src_addr   = {s1, s0};
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pipe_stall = 0;
    pipe_flush = 0;
    drive(1, 0, 0, 0, 5'd5, 5'd5);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== 7'd0) begin
      bad++;
      $display("FAIL reset_idle got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, 7'd0);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 5'd5, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 5'd5);
    want = ev(0, 2'd0, 2'd1);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL b2b_stage0 got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    step();
    drive(1, 0, 0, 0, 5'd5, 5'd5);
    want = ev(0, 2'd2, 2'd2);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL b2b_stage1 got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    idle();
  endtask

  task automatic test_double_producer();
    drive(1, 1, 5'd7, 0, 0, 0);
    step();
    drive(1, 1, 5'd7, 0, 0, 0);
    step();
    drive(1, 0, 0, 0, 5'd7, 0);
    want = ev(0, 2'd1, 2'd0);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL double_prod got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    idle();
  endtask

  task automatic test_x0_nowrite();
    drive(1, 1, 5'd0, 0, 0, 0);
    step();
    drive(1, 0, 5'd3, 0, 0, 0);
    want = ev(0, 2'd0, 2'd0);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL x0_write got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    step();
    drive(1, 0, 0, 0, 5'd0, 5'd3);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL no_write got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    idle();
  endtask

  task automatic test_late_stall();
    drive(1, 1, 5'd9, 1, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 5'd9);
`ifdef DIST_FWD_LATE_STALL_EN
    want = ev(1, 2'd0, 2'd1);
`else
    want = ev(0, 2'd0, 2'd1);
`endif
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL late_first got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    step();
    want = ev(0, 2'd0, 2'd2);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL late_second got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    idle();
  endtask

  task automatic test_freeze();
    drive(1, 1, 5'd6, 0, 0, 0);
    step();
    pipe_stall = 1;
    drive(1, 0, 0, 0, 5'd6, 5'd6);
    for (int i = 0; i < 3; i++) begin
      want = ev(0, 2'd1, 2'd1);
      total++;
      if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
        bad++;
        $display("FAIL freeze_%0d got=%b want=%b", i,
                 {hazard_stall, fwd_hit, fwd_sel}, want);
      end
      step();
    end
    pipe_stall = 0;
    step();
    #1;
    want = ev(0, 2'd2, 2'd2);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL freeze_release got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    idle();
  endtask

  task automatic test_flush();
    pipe_flush = 1;
    drive(1, 1, 5'd4, 0, 0, 0);
    step();
    pipe_flush = 0;
    drive(1, 0, 0, 0, 5'd4, 5'd4);
    want = ev(0, 2'd0, 2'd0);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL flush got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    idle();
  endtask

  task automatic test_depth_edge();
    drive(1, 1, 5'd10, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    drive(0, 0, 0, 0, 5'd10, 0);
    want = ev(0, 2'd3, 2'd0);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL oldest_stage got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    step();
    want = ev(0, 2'd0, 2'd0);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL discarded got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 1, 5'd8, 0, 0, 0);
    step();
    pipe_stall = 1;
    drive(1, 0, 0, 0, 0, 5'd8);
    want = ev(0, 2'd0, 2'd1);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL pre_reset got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    #2;
    reset_n = 1'b0;
    #1;
    want = ev(0, 2'd0, 2'd0);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    step();
    reset_n = 1'b1;
    pipe_stall = 0;
    step();
    drive(1, 0, 0, 0, 5'd8, 5'd8);
    total++;
    if ({hazard_stall, fwd_hit, fwd_sel} !== want) begin
      bad++;
      $display("FAIL post_reset got=%b want=%b",
               {hazard_stall, fwd_hit, fwd_sel}, want);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_double_producer();
    test_x0_nowrite();
    test_late_stall();
    test_freeze();
    test_flush();
    test_depth_edge();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
